// File: rtl/step_controller_if.sv
// Bundle of the CPU step-controller control and status signals.
// The bench or button logic takes the master side; the controller takes the slave side.
interface step_controller_if;
  logic       step;
  logic       run_toggle;
  logic [3:0] burst_len;
  logic       halt;
  logic       cpu_en;
  logic       busy;
  logic       halted;
  logic [1:0] state_dbg;

  modport master (
    output step, run_toggle, burst_len, halt,
    input  cpu_en, busy, halted, state_dbg
  );

  modport slave (
    input  step, run_toggle, burst_len, halt,
    output cpu_en, busy, halted, state_dbg
  );
endinterface

// File: rtl/step_controller.sv
// Gates CPU advance: N-pulse bursts per step, a divided free-running mode,
// and a sticky halted state that needs a fresh button press to leave.
module step_controller #(
  parameter int RUN_DIV = 4,
  parameter int DIV_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  step_controller_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BURST  = 2'b01;
  localparam logic [1:0] RUN    = 2'b10;
  localparam logic [1:0] HALTED = 2'b11;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             div_hit;

  assign div_hit = (div_q == DIV_LAST);

  // A run_toggle in the enable cycle stops the run without one last pulse.
  assign bus.cpu_en    = ((state_q == BURST) && !bus.halt) ||
                         ((state_q == RUN) && div_hit && !bus.halt && !bus.run_toggle);
  assign bus.busy      = (state_q == BURST) || (state_q == RUN);
  assign bus.halted    = (state_q == HALTED);
  assign bus.state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (bus.run_toggle) begin
          state_d = RUN;
          div_d   = '0;
        end else if (bus.step) begin
          state_d = BURST;
          rem_d   = (bus.burst_len == 4'd0) ? 4'd1 : bus.burst_len;
        end
      end
      BURST: begin
        if (bus.halt) begin
          state_d = HALTED;
          rem_d   = 4'd0;
        end else if (rem_q <= 4'd1) begin
          state_d = IDLE;
          rem_d   = 4'd0;
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end
      RUN: begin
        if (bus.halt) begin
          state_d = HALTED;
          div_d   = '0;
        end else if (bus.run_toggle) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_hit ? '0 : div_q + DIV_W'(1);
        end
      end
      HALTED: begin
        if (!bus.halt && (bus.step || bus.run_toggle)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 4'd0;
        div_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: bursts, divided run, halt handling,
// async reset, plus a second instance built with RUN_DIV=1.
module tb_step_controller;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  step_controller_if bus ();
  step_controller_if bus1 ();

  step_controller #(.RUN_DIV(4), .DIV_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  step_controller #(.RUN_DIV(1), .DIV_W(8)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle's inputs at the falling edge and settle before sampling.
  task automatic cyc(input logic s, input logic rt, input logic h);
    @(negedge clock);
    bus.step       = s;
    bus.run_toggle = rt;
    bus.halt       = h;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    bus.step = 1'b1;
    #1;
    checks++;
    if (bus.state_dbg !== 2'b00 || bus.cpu_en !== 1'b0 || bus.busy !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: state=%b cpu_en=%b busy=%b halted=%b, required 00 0 0 0",
               bus.state_dbg, bus.cpu_en, bus.busy, bus.halted);
    end
    cyc(1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.state_dbg !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ignores_pulses: state=%b, required 00", bus.state_dbg);
    end
    bus.step = 1'b0;
    bus.run_toggle = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_burst3();
    int pulses;
    pulses = 0;
    bus.burst_len = 4'd3;
    cyc(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.cpu_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst3_step_cycle: cpu_en=%b, required 0", bus.cpu_en);
    end
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (bus.cpu_en === 1'b1) pulses++;
      checks++;
      if (bus.cpu_en !== (i <= 3) || bus.busy !== (i <= 3)) begin
        errors++;
        $display("[TB] FAIL burst3_cycle%0d: cpu_en=%b busy=%b, required %b %b",
                 i, bus.cpu_en, bus.busy, (i <= 3), (i <= 3));
      end
    end
    checks++;
    if (pulses != 3 || bus.state_dbg !== 2'b00) begin
      errors++;
      $display("[TB] FAIL burst3_total: pulses=%0d state=%b, required 3 00", pulses, bus.state_dbg);
    end
  endtask

  task automatic test_burst0();
    int pulses;
    pulses = 0;
    bus.burst_len = 4'd0;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (bus.cpu_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL burst0_single: pulses=%0d busy=%b, required 1 0", pulses, bus.busy);
    end
  endtask

  task automatic test_run();
    int pulses;
    pulses = 0;
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.cpu_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_entry_cycle: cpu_en=%b, required 0", bus.cpu_en);
    end
    for (int i = 1; i <= 20; i++) begin
      cyc((i == 10), 1'b0, 1'b0);
      if (bus.cpu_en === 1'b1) pulses++;
      checks++;
      if (bus.cpu_en !== ((i % 4) == 0) || bus.state_dbg !== 2'b10) begin
        errors++;
        $display("[TB] FAIL run_cycle%0d: cpu_en=%b state=%b, required %b 10",
                 i, bus.cpu_en, bus.state_dbg, ((i % 4) == 0));
      end
    end
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("[TB] FAIL run_pulse_count: pulses=%0d, required 5", pulses);
    end
    for (int i = 21; i <= 23; i++) cyc(1'b0, 1'b0, 1'b0);
    // Cycle 24 would be an enable cycle; the toggle must suppress it.
    cyc(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.cpu_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_exit_suppress: cpu_en=%b, required 0", bus.cpu_en);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (bus.cpu_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.state_dbg !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_exit_idle: pulses=%0d state=%b busy=%b, required 0 00 0",
               pulses, bus.state_dbg, bus.busy);
    end
  endtask

  task automatic test_halt();
    int pulses;
    pulses = 0;
    bus.burst_len = 4'd5;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    if (bus.cpu_en === 1'b1) pulses++;
    cyc(1'b0, 1'b0, 1'b1);
    if (bus.cpu_en === 1'b1) pulses++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (bus.cpu_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.halted !== 1'b1 || bus.state_dbg !== 2'b11 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_mid_burst: pulses=%0d halted=%b state=%b busy=%b, required 1 1 11 0",
               pulses, bus.halted, bus.state_dbg, bus.busy);
    end
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.state_dbg !== 2'b11) begin
      errors++;
      $display("[TB] FAIL halt_ignores_step: state=%b, required 11", bus.state_dbg);
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.state_dbg !== 2'b11) begin
      errors++;
      $display("[TB] FAIL halt_release_no_pulse: state=%b, required 11", bus.state_dbg);
    end
    cyc(1'b1, 1'b0, 1'b0);
    if (bus.cpu_en === 1'b1) pulses++;
    cyc(1'b0, 1'b0, 1'b0);
    if (bus.cpu_en === 1'b1) pulses++;
    cyc(1'b0, 1'b0, 1'b0);
    if (bus.cpu_en === 1'b1) pulses++;
    checks++;
    if (pulses != 1 || bus.state_dbg !== 2'b00 || bus.halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_exit_idle: pulses=%0d state=%b halted=%b, required 1 00 0",
               pulses, bus.state_dbg, bus.halted);
    end
  endtask

  task automatic test_same_cycle();
    int pulses;
    pulses = 0;
    bus.burst_len = 4'd4;
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (bus.cpu_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.state_dbg !== 2'b10) begin
      errors++;
      $display("[TB] FAIL same_cycle_run_wins: pulses=%0d state=%b, required 0 10",
               pulses, bus.state_dbg);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.cpu_en !== 1'b1 || bus.state_dbg !== 2'b10) begin
      errors++;
      $display("[TB] FAIL async_pre_run: cpu_en=%b state=%b, required 1 10", bus.cpu_en, bus.state_dbg);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.state_dbg !== 2'b00 || bus.cpu_en !== 1'b0 || bus.busy !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_outputs: state=%b cpu_en=%b busy=%b halted=%b, required 00 0 0 0",
               bus.state_dbg, bus.cpu_en, bus.busy, bus.halted);
    end
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.burst_len = 4'd1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.cpu_en !== 1'b1 || bus.state_dbg !== 2'b01) begin
      errors++;
      $display("[TB] FAIL async_resume: cpu_en=%b state=%b, required 1 01", bus.cpu_en, bus.state_dbg);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_run_div1();
    @(negedge clock);
    bus1.run_toggle = 1'b1;
    #1;
    checks++;
    if (bus1.cpu_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div1_entry: cpu_en=%b, required 0", bus1.cpu_en);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      bus1.run_toggle = 1'b0;
      #1;
      checks++;
      if (bus1.cpu_en !== 1'b1) begin
        errors++;
        $display("[TB] FAIL div1_cycle%0d: cpu_en=%b, required 1", i, bus1.cpu_en);
      end
    end
    @(negedge clock);
    bus1.run_toggle = 1'b1;
    #1;
    checks++;
    if (bus1.cpu_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div1_exit_suppress: cpu_en=%b, required 0", bus1.cpu_en);
    end
    @(negedge clock);
    bus1.run_toggle = 1'b0;
    #1;
    checks++;
    if (bus1.state_dbg !== 2'b00 || bus1.cpu_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div1_idle: state=%b cpu_en=%b, required 00 0", bus1.state_dbg, bus1.cpu_en);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.step = 1'b0;
    bus.run_toggle = 1'b0;
    bus.burst_len = 4'd0;
    bus.halt = 1'b0;
    bus1.step = 1'b0;
    bus1.run_toggle = 1'b0;
    bus1.burst_len = 4'd0;
    bus1.halt = 1'b0;

    test_reset();
    test_burst3();
    test_burst0();
    test_run();
    test_halt();
    test_same_cycle();
    test_async_reset();
    test_run_div1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter RUN_DIV, default 4, meaning RUN mode issues one cpu_en every RUN_DIV clocks; legal values are 1 to 255.
REQ-002 SHALL have parameter DIV_W, default 8, meaning the width of the run-rate divider counter.
REQ-003 SHALL have port clock, input, 1, the single system clock; all state changes occur on the posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port step, input, 1, a single-cycle pulse from the step-button FSM.
REQ-006 SHALL have port run_toggle, input, 1, a single-cycle pulse from the run-button FSM.
REQ-007 SHALL have port burst_len, input, 4, the number of cpu_en pulses per step; 0 is treated as 1.
REQ-008 SHALL have port halt, input, 1, the CPU halt status level.
REQ-009 SHALL have port cpu_en, output, 1, the single-cycle advance enable to the CPU datapath.
REQ-010 SHALL have port busy, output, 1, high while in BURST or RUN.
REQ-011 SHALL have port halted, output, 1, high while in HALTED.
REQ-012 SHALL have port state_dbg, output, 2, the current state encoding.

Function
REQ-013 SHALL implement states IDLE=2'b00, BURST=2'b01, RUN=2'b10 and HALTED=2'b11, with state_dbg equal to the state register.
REQ-014 SHALL give halt=1 top priority: from IDLE, BURST or RUN, the next state is HALTED regardless of step or run_toggle.
REQ-015 SHALL, in IDLE with step=1 and run_toggle=0, go to BURST and load remaining = (burst_len==0 ? 1 : burst_len).
REQ-016 SHALL, in IDLE with run_toggle=1, go to RUN and clear the divider; when step and run_toggle arrive in the same cycle, run_toggle wins.
REQ-017 SHALL make cpu_en combinational: cpu_en = (state==BURST && !halt) || (state==RUN && div==RUN_DIV-1 && !halt && !run_toggle).
REQ-018 SHALL, in BURST, assert cpu_en every cycle and decrement remaining each cycle.
REQ-019 SHALL leave BURST for IDLE in the cycle that cpu_en issues with remaining==1, giving exactly N consecutive pulses starting the cycle after step is sampled.
REQ-020 SHALL ignore step and run_toggle while in BURST.
REQ-021 SHALL, in RUN, count the divider 0..RUN_DIV-1 and wrap to 0; the first cpu_en occurs RUN_DIV cycles after entering RUN.
REQ-022 SHALL, for RUN_DIV=1, assert cpu_en every RUN cycle.
REQ-023 SHALL, in RUN with run_toggle=1, go to IDLE, clear the divider and suppress cpu_en that cycle.
REQ-024 SHALL ignore step while in RUN.
REQ-025 SHALL hold cpu_en=0 in HALTED.
REQ-026 SHALL leave HALTED for IDLE only when halt==0 and step or run_toggle is sampled, issuing no cpu_en on exit.
REQ-027 SHALL ignore pulses received in HALTED while halt==1.
REQ-028 SHALL NOT let the divider or remaining count underflow or wrap outside their stated ranges.

Reset
REQ-029 SHALL, when reset is asserted at any time including mid-BURST or mid-RUN, force state=IDLE, remaining=0, div=0, and cpu_en=busy=halted=0, with state_dbg=2'b00, immediately and without waiting for a clock edge.
REQ-030 SHALL ignore step and run_toggle while reset is high, and resume normal operation on the first posedge after reset deasserts.

Verification
REQ-031 SHALL verify: burst_len=3, step pulse in IDLE -> cpu_en high for exactly 3 consecutive cycles starting next cycle, then IDLE with busy=0.
REQ-032 SHALL verify: burst_len=0, step pulse -> exactly 1 cpu_en pulse.
REQ-033 SHALL verify: RUN_DIV=4, run_toggle pulse, 20 cycles -> cpu_en on cycles 4, 8, 12, 16, 20 after entry; second run_toggle -> IDLE with no further pulses.
REQ-034 SHALL verify: halt=1 during the 2nd cycle of a 5-pulse burst -> only 1 cpu_en issued, halted=1; step pulse while halt=1 is ignored; halt=0 then step -> IDLE with no cpu_en.
REQ-035 SHALL verify: step and run_toggle in the same IDLE cycle -> RUN entered with no burst pulses.
REQ-036 SHALL verify: reset asserted asynchronously mid-RUN between clock edges -> all outputs 0 and state_dbg=2'b00 before the next edge.
